gate_bist: RTL and testbench
============================

# gate_bist

Synthesizable built-in self-test engine for a two-input combinational gate such as `basic_or`. It drives the gate under test through its full truth table, 00, 01, 10 then 11, and holds each vector for a programmable settle time. It samples the gate's output, compares it against a parameterized expected truth table, and reports pass/fail, a per-vector failure mask and the first failing vector. It is the hardware counterpart of the directed gate benches: it sits beside a gate instance and performs the same stimulus/check sequence on-chip.

## Interface
Parameters:
- `TRUTH_TABLE`, default 4'b1110 (OR): bit i is the expected `dut_out` for vector index i = {in1,in2}.
- `SETTLE`, default 4, legal range ≥1: cycles a vector is held before its sampling cycle.
- `CNT_W`, default 3: width of `fail_count`.

Ports (single clock `clk`; reset `rst` is synchronous and active-high):
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  one-cycle request to begin a test run.
- `dut_in1`  out  1  gate input a, registered.
- `dut_in2`  out  1  gate input b, registered.
- `dut_out`  in  1  gate output under test.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  high from run completion until the next accepted start or reset.
- `pass`  out  1  1 when `fail_mask`==0; valid only while `done`=1, otherwise 0.
- `fail_count`  out  CNT_W  number of failing vectors, saturating at 2^CNT_W−1.
- `first_fail_idx`  out  2  index of the first failing vector; 0 if none.
- `fail_mask`  out  4  bit i set if vector i failed.

## Operation
- States: IDLE, WAIT, CHECK, DONE.
- IDLE: `dut_in1`/`dut_in2`=00, `busy`=0.
- Start accepted (`start`=1 in IDLE or DONE):
  - clear `fail_mask`, `fail_count`, `first_fail_idx` and `done`;
  - set idx=0 and load vector 0 onto the `dut_in` registers;
  - load wait_cnt=SETTLE−1 and go to WAIT.
- WAIT: if wait_cnt==0 go to CHECK; otherwise decrement.
- CHECK:
  - Compare `dut_out` with TRUTH_TABLE[idx].
  - On mismatch: set fail_mask[idx] and increment `fail_count` (saturating). If this is the first failure of the run, record `first_fail_idx`=idx.
  - If idx==3, go to DONE and drive `dut_in` to 00.
  - Otherwise increment idx, load the next vector and wait_cnt=SETTLE−1, and go to WAIT.
- DONE: `done`=1, `busy`=0, results held stable.
- `start` in WAIT or CHECK is ignored; it is not queued.
- `busy`=1 exactly in WAIT and CHECK.

## Timing
- Reset values: `dut_in1`=0, `dut_in2`=0, `busy`=0, `done`=0, `pass`=0, `fail_count`=0, `first_fail_idx`=0, `fail_mask`=0, state=IDLE.
- Each vector is driven for SETTLE+1 cycles. `dut_out` is sampled at the clock edge that ends the CHECK cycle.
- Latency: `done` rises 4×(SETTLE+1) cycles after the edge that accepts `start`. With SETTLE=4 this is 20 cycles.
- `busy` rises in the cycle after the accepting edge.
- Restart from DONE: `done`, `pass` and the result outputs drop to 0 in the cycle after the accepting edge.
- `rst` mid-run: all outputs and state take their reset values at that edge. No partial results are kept and `dut_in` returns to 00.
- `rst` and `start` in the same cycle: `rst` wins and `start` is dropped.
- The outputs are registered with no combinational path from `dut_out`. `pass` is derived from registered state only.

## Structure
- `gate_bist_pkg` contains:
  - the `state_t` enum (IDLE/WAIT/CHECK/DONE);
  - `VEC_COUNT`=4;
  - truth-table constants `TT_OR`=4'b1110, `TT_AND`=4'b1000, `TT_XOR`=4'b0110, `TT_NAND`=4'b0111, `TT_NOR`=4'b0001.
- Sub-module `gate_bist_timer`: a loadable settle down-counter with `load`, `value` and `zero` signals. It is instantiated once.
- Vector sequencing, comparison and result registers live in `gate_bist`.

## Test plan
- Good gate: `basic_or` as DUT, TRUTH_TABLE=`TT_OR`, SETTLE=4, pulse `start`.
  - `dut_in` steps through 00, 01, 10, 11, holding each vector 5 cycles.
  - `done` rises after 20 cycles with `pass`=1, `fail_count`=0, `fail_mask`=0.
- Stuck-at-0 gate (`dut_out` tied 0) with `TT_OR` → `fail_mask`=4'b1110, `fail_count`=3, `first_fail_idx`=1, `pass`=0.
- Wrong expectation: OR gate as DUT checked against `TT_AND` → `fail_mask`=4'b0110, `fail_count`=2, `first_fail_idx`=1.
- Reset mid-run: assert `rst` 7 cycles after start.
  - All outputs read 0 on the next cycle and `busy`=0.
  - A following `start` completes with `pass`=1.
- Ignored start: a `start` pulse 5 cycles into a run leaves `done` timing unchanged at cycle 20.
- Restart from DONE:
  - `start` clears `done`, `pass` and `fail_mask` on the next cycle.
  - SETTLE=1 variant: `done` rises after 8 cycles.

Source files
------------

// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate_bist self-test engine.
`timescale 1ns/1ps
package gate_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned VEC_COUNT = 4;
    localparam int unsigned IDX_W     = 2;

    // Expected outputs indexed by vector {in1,in2}.
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;

endpackage

// File: rtl/gate_bist_timer.sv
// Loadable settle down-counter; zero flag is registered alongside the count.
`timescale 1ns/1ps
module gate_bist_timer #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         zero_q, zero_d;

    always_comb begin
        cnt_d  = cnt_q;
        zero_d = zero_q;
        if (load_i) begin
            cnt_d  = value_i;
            zero_d = (value_i == '0);
        end else if (cnt_q != '0) begin
            cnt_d  = cnt_q - W'(1);
            zero_d = (cnt_q == W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= zero_d;
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/gate_bist.sv
// Built-in self-test for a two-input gate: walks 00,01,10,11, settles, samples
// the gate output against TRUTH_TABLE and records mask/count/first failure.
`timescale 1ns/1ps
module gate_bist
    import gate_bist_pkg::*;
#(
    parameter logic [3:0]  TRUTH_TABLE = TT_OR,
    parameter int unsigned SETTLE      = 4,
    parameter int unsigned CNT_W       = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             dut_in1,
    output logic             dut_in2,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] fail_count,
    output logic [1:0]       first_fail_idx,
    output logic [3:0]       fail_mask
);

    localparam int unsigned TIMER_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX     = '1;
    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(VEC_COUNT - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       vec_q, vec_d;
    logic [3:0]       mask_q, mask_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       first_q, first_d;
    logic             timer_load;
    logic             timer_zero;
    logic             accept;

    assign accept = start && ((state_q == IDLE) || (state_q == DONE));

    gate_bist_timer #(.W(TIMER_W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (timer_load),
        .value_i (SETTLE_LOAD),
        .zero_o  (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start)      state_d = WAIT;
            WAIT:       if (timer_zero) state_d = CHECK;
            CHECK:      state_d = (idx_q == LAST_IDX) ? DONE : WAIT;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        pass = 1'b0;
        case (state_q)
            WAIT, CHECK: busy = 1'b1;
            DONE: begin
                done = 1'b1;
                pass = (mask_q == 4'b0000);
            end
            default: ;
        endcase
    end

    // Vector sequencing and result accumulation.
    always_comb begin
        idx_d      = idx_q;
        vec_d      = vec_q;
        mask_d     = mask_q;
        cnt_d      = cnt_q;
        first_d    = first_q;
        timer_load = 1'b0;
        if (accept) begin
            idx_d      = '0;
            vec_d      = 2'b00;
            mask_d     = 4'b0000;
            cnt_d      = '0;
            first_d    = 2'b00;
            timer_load = 1'b1;
        end else if (state_q == CHECK) begin
            if (dut_out != TRUTH_TABLE[idx_q]) begin
                mask_d[idx_q] = 1'b1;
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                if (mask_q == 4'b0000) first_d = idx_q;
            end
            if (idx_q == LAST_IDX) begin
                vec_d = 2'b00;
            end else begin
                idx_d      = idx_q + IDX_W'(1);
                vec_d      = idx_q + 2'(1);
                timer_load = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            vec_q   <= 2'b00;
            mask_q  <= 4'b0000;
            cnt_q   <= '0;
            first_q <= 2'b00;
        end else begin
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
        end
    end

    assign dut_in1        = vec_q[1];
    assign dut_in2        = vec_q[0];
    assign fail_mask      = mask_q;
    assign fail_count     = cnt_q;
    assign first_fail_idx = first_q;

endmodule

// File: tb/tb_gate_bist.sv
// Bench for gate_bist: two instances (OR/SETTLE=4/CNT_W=3, AND/SETTLE=1/CNT_W=1)
// driven by behavioural gate functions, checked against a truth-table model.
`timescale 1ns/1ps
module tb_gate_bist;
    import gate_bist_pkg::*;

    localparam int unsigned S0 = 4;
    localparam int unsigned S1 = 1;
    localparam int unsigned W0 = 3;
    localparam int unsigned W1 = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start [2];
    logic       din1  [2];
    logic       din2  [2];
    logic       dout  [2];
    logic       busy  [2];
    logic       done  [2];
    logic       pass  [2];
    logic [1:0] ffi   [2];
    logic [3:0] fmask [2];
    logic [3:0] gate  [2];
    logic [2:0] fc0;
    logic [0:0] fc1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Behavioural gates under test: output is the gate function at {in1,in2}.
    always_comb begin
        dout[0] = gate[0][{din1[0], din2[0]}];
        dout[1] = gate[1][{din1[1], din2[1]}];
    end

    gate_bist #(.TRUTH_TABLE(TT_OR), .SETTLE(S0), .CNT_W(W0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]),
        .dut_in1(din1[0]), .dut_in2(din2[0]), .dut_out(dout[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .fail_count(fc0), .first_fail_idx(ffi[0]), .fail_mask(fmask[0])
    );

    gate_bist #(.TRUTH_TABLE(TT_AND), .SETTLE(S1), .CNT_W(W1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]),
        .dut_in1(din1[1]), .dut_in2(din2[1]), .dut_out(dout[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .fail_count(fc1), .first_fail_idx(ffi[1]), .fail_mask(fmask[1])
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int get_fc(input int id);
        return (id == 0) ? int'(fc0) : int'(fc1);
    endfunction

    task automatic check_idle(input int id, input string tag);
        check($sformatf("%s busy%0d", tag, id), int'(busy[id]), 0);
        check($sformatf("%s done%0d", tag, id), int'(done[id]), 0);
        check($sformatf("%s pass%0d", tag, id), int'(pass[id]), 0);
        check($sformatf("%s in1_%0d", tag, id), int'(din1[id]), 0);
        check($sformatf("%s in2_%0d", tag, id), int'(din2[id]), 0);
        check($sformatf("%s cnt%0d", tag, id), get_fc(id), 0);
        check($sformatf("%s first%0d", tag, id), int'(ffi[id]), 0);
        check($sformatf("%s mask%0d", tag, id), int'(fmask[id]), 0);
    endtask

    // One run on instance id with gate function g; optional ignored start at
    // cycle ign_at and reset asserted at cycle rst_at (-1 disables either).
    task automatic run(input int id, input logic [3:0] g, input int ign_at, input int rst_at);
        int s, w, len, vec, cmax, exp_cnt, exp_first;
        logic [3:0] tt, exp_mask;
        s   = (id == 0) ? S0 : S1;
        w   = (id == 0) ? W0 : W1;
        tt  = (id == 0) ? TT_OR : TT_AND;
        len = 4 * (s + 1);
        exp_mask = g ^ tt;
        cmax     = (1 << w) - 1;
        exp_cnt  = ($countones(exp_mask) > cmax) ? cmax : $countones(exp_mask);
        exp_first = 0;
        for (int i = 3; i >= 0; i--) if (exp_mask[i]) exp_first = i;
        gate[id] = g;
        @(negedge clk);
        start[id] = 1'b1;
        @(posedge clk);
        #1;
        start[id] = 1'b0;
        for (int k = 0; k <= len; k++) begin
            vec = (k < len) ? k / (s + 1) : 0;
            check($sformatf("busy%0d k=%0d", id, k), int'(busy[id]), int'(k < len));
            check($sformatf("done%0d k=%0d", id, k), int'(done[id]), int'(k == len));
            check($sformatf("in1_%0d k=%0d", id, k), int'(din1[id]), (vec >> 1) & 1);
            check($sformatf("in2_%0d k=%0d", id, k), int'(din2[id]), vec & 1);
            if (k < len) check($sformatf("pass%0d k=%0d", id, k), int'(pass[id]), 0);
            if (k == 0) begin
                check($sformatf("clr_mask%0d", id), int'(fmask[id]), 0);
                check($sformatf("clr_cnt%0d", id), get_fc(id), 0);
            end
            if (k == len) begin
                check($sformatf("mask%0d g=%b", id, g), int'(fmask[id]), int'(exp_mask));
                check($sformatf("cnt%0d g=%b", id, g), get_fc(id), exp_cnt);
                check($sformatf("first%0d g=%b", id, g), int'(ffi[id]), exp_first);
                check($sformatf("pass%0d g=%b", id, g), int'(pass[id]), int'(exp_mask == 4'b0000));
                break;
            end
            if (k == ign_at) start[id] = 1'b1;
            if (k == rst_at) rst = 1'b1;
            @(posedge clk);
            #1;
            start[id] = 1'b0;
            if (k == rst_at) begin
                rst = 1'b0;
                check_idle(id, "midrst");
                return;
            end
        end
    endtask

    initial begin
        int id, ign, rat;
        logic [3:0] g;
        start[0] = 1'b0;
        start[1] = 1'b0;
        gate[0]  = 4'b0000;
        gate[1]  = 4'b0000;
        rst      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle(0, "reset");
        check_idle(1, "reset");
        rst = 1'b0;

        run(0, TT_OR,   -1, -1);
        run(0, 4'b0000, -1, -1);
        run(1, TT_OR,   -1, -1);
        run(0, TT_OR,    5, -1);
        run(0, 4'($urandom), -1, 6);
        run(0, TT_OR,   -1, -1);
        run(1, TT_AND,  -1, -1);
        run(1, TT_XOR,   2, -1);

        // Reset and start on the same edge: reset wins, nothing starts.
        @(negedge clk);
        start[0] = 1'b1;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        rst      = 1'b0;
        check_idle(0, "rst_start");
        @(posedge clk);
        #1;
        check_idle(0, "rst_start2");

        for (int it = 0; it < 12; it++) begin
            id  = int'($urandom_range(0, 1));
            g   = 4'($urandom);
            ign = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : -1;
            rat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            run(id, g, ign, rat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
